// File: rtl/sha256_pkg.sv
// Shared constants and FSM state type for the SHA-256 message padder.
package sha256_pkg;

   localparam int unsigned BLOCK_WORDS = 16;
   localparam int unsigned LEN_HI_IDX  = 14;
   localparam logic [7:0]  PAD_MARK    = 8'h80;
   localparam int unsigned LEN_W       = 64;

   typedef enum logic [2:0] {
      DATA   = 3'd0,
      MARK   = 3'd1,
      ZFILL  = 3'd2,
      ZPAD   = 3'd3,
      LEN_HI = 3'd4,
      LEN_LO = 3'd5
   } pad_state_t;

endpackage

// File: rtl/sha256_byte_merge.sv
// Keeps the first k bytes of a big-endian half word, places the 0x80 marker in byte k
// and zeroes the rest; k=0 yields the bare marker word.
module sha256_byte_merge
   import sha256_pkg::*;
(
   input  logic [31:0] half,
   input  logic [1:0]  k,
   output logic [31:0] merged_c
);

   always_comb begin
      merged_c = '0;
      for (int b = 0; b < 4; b++) begin
         if (2'(b) < k) begin
            merged_c[31-8*b -: 8] = half[31-8*b -: 8];
         end else if (2'(b) == k) begin
            merged_c[31-8*b -: 8] = PAD_MARK;
         end
      end
   end

endmodule

// File: rtl/sha256_msg_padder.sv
// Byte-stream to FIPS 180-4 padded 32-bit word stream for the SHA-256 core:
// data, 0x80 marker, zero fill and the 64-bit bit length, 16 words per block.
module sha256_msg_padder
   import sha256_pkg::*;
#(
   parameter int unsigned IN_BYTES = 4,
   parameter int unsigned NB_W     = $clog2(IN_BYTES)
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [8*IN_BYTES-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  in_last,
   input  logic [NB_W-1:0]       in_numbyte,
   output logic [31:0]           out_word,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_first,
   output logic                  out_blk_end,
   output logic                  out_msg_end
);

   localparam int unsigned IN_W  = 8 * IN_BYTES;
   localparam int unsigned CNT_W = 61;
   localparam bit          WIDE  = (IN_BYTES == 8);

   pad_state_t         state, state_nx;
   logic [3:0]         wcnt;
   logic [CNT_W-1:0]   byte_cnt;
   logic               rdy_q;
   logic               lo_pend;
   logic [31:0]        lo_word;
   logic               lo_last;
   logic [2:0]         lo_vb;

   logic               load_ok, acc, hi_last;
   logic [3:0]         nbytes, acc_bytes;
   logic [31:0]        hi_half, sel_word, merged_c;
   logic               sel_last;
   logic [2:0]         sel_vb;
   logic [LEN_W-1:0]   msg_len;
   logic               emit, emit_end, push_lo, clr;
   logic [31:0]        emit_word;

   // Marker landing in word 13 or earlier leaves room for the length in this block;
   // later markers need a zero-filled extra block.
   function automatic pad_state_t pad_next(input logic [3:0] w);
      if (w == 4'(LEN_HI_IDX)) begin
         return LEN_HI;
      end else if (w == 4'(LEN_HI_IDX + 1)) begin
         return ZFILL;
      end else begin
         return ZPAD;
      end
   endfunction

   assign load_ok   = !out_valid || out_ready;
   assign in_ready  = rdy_q && (state == DATA) && !lo_pend && load_ok;
   assign acc       = in_valid && in_ready;
   assign nbytes    = (in_numbyte == '0) ? 4'(IN_BYTES) : 4'(in_numbyte);
   assign acc_bytes = in_last ? nbytes : 4'(IN_BYTES);
   assign hi_half   = in_data[IN_W-1 -: 32];
   assign hi_last   = in_last && (nbytes <= 4'd4);
   assign msg_len   = {byte_cnt, 3'b000};

   // Pending low half takes priority over a fresh input word
   assign sel_word  = lo_pend ? lo_word : hi_half;
   assign sel_last  = lo_pend ? lo_last : hi_last;
   assign sel_vb    = lo_pend ? lo_vb : (hi_last ? nbytes[2:0] : 3'd4);

   sha256_byte_merge u_merge (
      .half     (sel_word),
      .k        (sel_vb[1:0]),
      .merged_c (merged_c)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= DATA;
      end else begin
         state <= state_nx;
      end
   end

   // Next state and the word to load into the output register
   always_comb begin
      state_nx  = state;
      emit      = 1'b0;
      emit_word = '0;
      emit_end  = 1'b0;
      push_lo   = 1'b0;
      clr       = 1'b0;
      if (load_ok) begin
         if (lo_pend || acc) begin
            emit      = 1'b1;
            emit_word = sel_word;
            if (sel_last) begin
               if (sel_vb == 3'd4) begin
                  state_nx = MARK;
               end else begin
                  emit_word = merged_c;
                  state_nx  = pad_next(wcnt + 4'd1);
               end
            end
            push_lo = WIDE && acc && !hi_last;
         end else begin
            case (state)
               MARK: begin
                  emit      = 1'b1;
                  emit_word = {PAD_MARK, 24'h0};
                  state_nx  = pad_next(wcnt + 4'd1);
               end
               ZFILL: begin
                  emit = 1'b1;
                  if (wcnt == 4'(BLOCK_WORDS - 1)) state_nx = ZPAD;
               end
               ZPAD: begin
                  emit = 1'b1;
                  if (wcnt == 4'(LEN_HI_IDX - 1)) state_nx = LEN_HI;
               end
               LEN_HI: begin
                  emit      = 1'b1;
                  emit_word = msg_len[LEN_W-1:32];
                  state_nx  = LEN_LO;
               end
               LEN_LO: begin
                  emit      = 1'b1;
                  emit_word = msg_len[31:0];
                  emit_end  = 1'b1;
                  clr       = 1'b1;
                  state_nx  = DATA;
               end
               default: ;
            endcase
         end
      end
   end

   // Output register, counters and the pending low half
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdy_q       <= 1'b0;
         out_word    <= '0;
         out_valid   <= 1'b0;
         out_first   <= 1'b0;
         out_blk_end <= 1'b0;
         out_msg_end <= 1'b0;
         wcnt        <= '0;
         byte_cnt    <= '0;
         lo_pend     <= 1'b0;
         lo_word     <= '0;
         lo_last     <= 1'b0;
         lo_vb       <= '0;
      end else begin
         rdy_q <= 1'b1;
         if (emit) begin
            out_word    <= emit_word;
            out_valid   <= 1'b1;
            out_first   <= (wcnt == 4'd0);
            out_blk_end <= (wcnt == 4'(BLOCK_WORDS - 1));
            out_msg_end <= emit_end;
            wcnt        <= clr ? 4'd0 : wcnt + 4'd1;
         end else if (out_ready) begin
            out_valid   <= 1'b0;
            out_first   <= 1'b0;
            out_blk_end <= 1'b0;
            out_msg_end <= 1'b0;
         end
         if (clr) begin
            byte_cnt <= '0;
         end else if (acc) begin
            byte_cnt <= byte_cnt + CNT_W'(acc_bytes);
         end
         if (push_lo) begin
            lo_pend <= 1'b1;
            lo_word <= in_data[31:0];
            lo_last <= in_last;
            lo_vb   <= in_last ? 3'(nbytes - 4'd4) : 3'd4;
         end else if (emit && lo_pend) begin
            lo_pend <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed bench for sha256_msg_padder with 4-byte and 8-byte input instances.
module tb_sha256_msg_padder;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   logic [31:0] a_in_data;
   logic        a_in_valid, a_in_ready, a_in_last;
   logic [1:0]  a_in_numbyte;
   logic [31:0] a_out_word;
   logic        a_out_valid, a_out_ready, a_out_first, a_out_blk_end, a_out_msg_end;

   logic [63:0] b_in_data;
   logic        b_in_valid, b_in_ready, b_in_last;
   logic [2:0]  b_in_numbyte;
   logic [31:0] b_out_word;
   logic        b_out_valid, b_out_ready, b_out_first, b_out_blk_end, b_out_msg_end;

   sha256_msg_padder #(.IN_BYTES(4)) dut_a (
      .clk(clk), .rst(rst),
      .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .in_last(a_in_last), .in_numbyte(a_in_numbyte),
      .out_word(a_out_word), .out_valid(a_out_valid), .out_ready(a_out_ready),
      .out_first(a_out_first), .out_blk_end(a_out_blk_end), .out_msg_end(a_out_msg_end)
   );

   sha256_msg_padder #(.IN_BYTES(8)) dut_b (
      .clk(clk), .rst(rst),
      .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_last(b_in_last), .in_numbyte(b_in_numbyte),
      .out_word(b_out_word), .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_first(b_out_first), .out_blk_end(b_out_blk_end), .out_msg_end(b_out_msg_end)
   );

   typedef struct packed {
      logic [31:0] w;
      logic        f;
      logic        be;
      logic        me;
   } obs_t;

   obs_t        qa[$], qb[$];
   logic [31:0] exp_q[$], abc_q[$];
   int          checks = 0;
   int          failures = 0;

   // Record every word the core side consumes; sampled mid-cycle before the next edge
   always @(negedge clk) begin
      #2;
      if (a_out_valid && a_out_ready) qa.push_back({a_out_word, a_out_first, a_out_blk_end, a_out_msg_end});
      if (b_out_valid && b_out_ready) qb.push_back({b_out_word, b_out_first, b_out_blk_end, b_out_msg_end});
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic send_a(input logic [31:0] d, input logic last, input logic [1:0] nb);
      int n = 0;
      a_in_data = d; a_in_last = last; a_in_numbyte = nb; a_in_valid = 1'b1;
      #1;
      while (a_in_ready !== 1'b1 && n < 200) begin
         @(negedge clk); #1; n++;
      end
      chk("a accept", 64'(n < 200), 64'(1));
      @(posedge clk);
      @(negedge clk);
      a_in_valid = 1'b0;
   endtask

   task automatic send_b(input logic [63:0] d, input logic last, input logic [2:0] nb);
      int n = 0;
      b_in_data = d; b_in_last = last; b_in_numbyte = nb; b_in_valid = 1'b1;
      #1;
      while (b_in_ready !== 1'b1 && n < 200) begin
         @(negedge clk); #1; n++;
      end
      chk("b accept", 64'(n < 200), 64'(1));
      @(posedge clk);
      @(negedge clk);
      b_in_valid = 1'b0;
   endtask

   task automatic wait_a(input int n);
      int c = 0;
      while (qa.size() < n && c < 400) begin
         @(negedge clk); c++;
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic wait_b(input int n);
      int c = 0;
      while (qb.size() < n && c < 400) begin
         @(negedge clk); c++;
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic compare(input string tag, input obs_t got[$], input logic [31:0] expw[$]);
      chk({tag, " count"}, 64'(got.size()), 64'(expw.size()));
      for (int i = 0; i < expw.size() && i < got.size(); i++) begin
         obs_t e;
         e.w  = expw[i];
         e.f  = (i % 16 == 0);
         e.be = (i % 16 == 15);
         e.me = (i == expw.size() - 1);
         chk($sformatf("%s w%0d", tag, i), 64'(got[i]), 64'(e));
      end
   endtask

   task automatic zero_to(input int n);
      while (exp_q.size() < n) exp_q.push_back(32'h0);
   endtask

   initial begin
      obs_t snap;
      logic snap_v;
      rst = 1'b0;
      a_in_data = '0; a_in_valid = 1'b0; a_in_last = 1'b0; a_in_numbyte = '0; a_out_ready = 1'b1;
      b_in_data = '0; b_in_valid = 1'b0; b_in_last = 1'b0; b_in_numbyte = '0; b_out_ready = 1'b1;
      #2 rst = 1'b1;
      #5;
      chk("reset outputs a", 64'({a_out_word, a_out_valid, a_out_first, a_out_blk_end, a_out_msg_end, a_in_ready}), 64'(0));
      chk("reset outputs b", 64'({b_out_word, b_out_valid, b_out_first, b_out_blk_end, b_out_msg_end, b_in_ready}), 64'(0));
      @(negedge clk) rst = 1'b0;
      #1 chk("in_ready before first edge", 64'(a_in_ready), 64'(0));
      @(posedge clk); #1;
      chk("in_ready after first edge", 64'(a_in_ready), 64'(1));
      @(negedge clk);

      // "abc" on the 4-byte instance
      abc_q = {32'h6162_6380};
      for (int i = 1; i < 15; i++) abc_q.push_back(32'h0);
      abc_q.push_back(32'h0000_0018);
      send_a(32'h6162_6300, 1'b1, 2'd3);
      wait_a(16);
      compare("abc4", qa, abc_q);
      qa.delete();

      // 55 bytes: marker in word 13, length fits in the same block
      exp_q.delete();
      for (int i = 0; i < 13; i++) begin
         send_a(32'hA0B0_C000 + 32'(i), 1'b0, 2'd0);
         exp_q.push_back(32'hA0B0_C000 + 32'(i));
      end
      send_a({24'hDEADBE, 8'hxx}, 1'b1, 2'd3);
      exp_q.push_back(32'hDEAD_BE80);
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h0000_01B8);
      wait_a(16);
      compare("len55", qa, exp_q);
      qa.delete();

      // 56 bytes: marker in word 14, length spills into a second block
      exp_q.delete();
      for (int i = 0; i < 14; i++) begin
         send_a(32'h5500_0000 + 32'(i), i == 13, 2'd0);
         exp_q.push_back(32'h5500_0000 + 32'(i));
      end
      exp_q.push_back(32'h8000_0000);
      exp_q.push_back(32'h0);
      zero_to(31);
      exp_q.push_back(32'h0000_01C0);
      wait_a(32);
      compare("len56", qa, exp_q);
      qa.delete();

      // Backpressure for 5 cycles mid-block with a spurious in_valid
      exp_q.delete();
      send_a(32'h0102_0304, 1'b0, 2'd0);
      send_a(32'h0506_0708, 1'b0, 2'd0);
      send_a({16'h090A, 16'hxxxx}, 1'b1, 2'd2);
      exp_q = {32'h0102_0304, 32'h0506_0708, 32'h090A_8000};
      zero_to(15);
      exp_q.push_back(32'h0000_0050);
      wait_a(6);
      a_out_ready = 1'b0;
      a_in_valid = 1'b1; a_in_data = 32'hFFFF_FFFF; a_in_last = 1'b1; a_in_numbyte = 2'd0;
      #1;
      snap   = {a_out_word, a_out_first, a_out_blk_end, a_out_msg_end};
      snap_v = a_out_valid;
      chk("stall valid", 64'(snap_v), 64'(1));
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); #1;
         chk($sformatf("stall hold c%0d", i),
             64'({a_out_word, a_out_first, a_out_blk_end, a_out_msg_end, a_out_valid, a_in_ready}),
             64'({snap, 1'b1, 1'b0}));
      end
      @(negedge clk);
      a_in_valid = 1'b0;
      a_out_ready = 1'b1;
      wait_a(16);
      compare("stall", qa, exp_q);
      qa.delete();

      // Async reset at word 7 of a data block, then "abc" again
      for (int i = 0; i < 8; i++) send_a(32'hC000_0000 + 32'(i), 1'b0, 2'd0);
      #1 chk("pre-reset word", 64'({a_out_word, a_out_valid}), 64'({32'hC000_0007, 1'b1}));
      #2 rst = 1'b1;
      #1;
      chk("async reset a", 64'({a_out_word, a_out_valid, a_out_first, a_out_blk_end, a_out_msg_end, a_in_ready}), 64'(0));
      chk("async reset b", 64'({b_out_word, b_out_valid, b_out_first, b_out_blk_end, b_out_msg_end, b_in_ready}), 64'(0));
      @(negedge clk) rst = 1'b0;
      qa.delete();
      qb.delete();
      #1 chk("in_ready after reset", 64'(a_in_ready), 64'(0));
      @(negedge clk);
      send_a(32'h6162_6300, 1'b1, 2'd3);
      wait_a(16);
      compare("abc after reset", qa, abc_q);
      qa.delete();

      // 8-byte instance: "abc", then 12 bytes ending on a full high half, then 6 bytes
      send_b(64'h6162_6300_0000_0000, 1'b1, 3'd3);
      wait_b(16);
      compare("abc8", qb, abc_q);
      qb.delete();

      exp_q = {32'h0102_0304, 32'h0506_0708, 32'h1122_3344, 32'h8000_0000};
      send_b(64'h0102_0304_0506_0708, 1'b0, 3'd0);
      send_b({32'h1122_3344, 32'hxxxx_xxxx}, 1'b1, 3'd4);
      zero_to(15);
      exp_q.push_back(32'h0000_0060);
      wait_b(16);
      compare("len12 b", qb, exp_q);
      qb.delete();

      exp_q = {32'hAABB_CCDD, 32'hEEFF_8000};
      send_b({48'hAABB_CCDD_EEFF, 16'hxxxx}, 1'b1, 3'd6);
      zero_to(15);
      exp_q.push_back(32'h0000_0030);
      wait_b(16);
      compare("len6 b", qb, exp_q);
      qb.delete();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
